// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and data access.
// Data wins ties, but a bounded data streak forces a waiting fetch through.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  input  logic              ifKill,
  output logic              ifDone,
  output logic [DATA_W-1:0] ifRdata,
  output logic              ifStall,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  input  logic [3:0]        dBe,
  output logic              dDone,
  output logic [DATA_W-1:0] dRdata,
  output logic              dStall,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic [3:0]        memBe,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memReady
);

  localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    D_BUSY   = 2'd2,
    IF_DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                we_q, we_d;
  logic                fetch_ok_s;
  logic                at_limit_s;

  assign fetch_ok_s = ifReq && !ifKill;
  assign at_limit_s = (streak_q == STREAK_MAX);

  // State, streak counter and latched transaction fields.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'h0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
    end
  end

  // Arbitration and transaction sequencing; fields are captured only on the grant edge.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    case (state_q)
      IDLE: begin
        if (dReq && !(fetch_ok_s && at_limit_s)) begin
          state_d = D_BUSY;
          addr_d  = dAddr;
          wdata_d = dWdata;
          be_d    = dBe;
          we_d    = dWe;
          if (!ifReq) begin
            streak_d = '0;
          end else if (!at_limit_s) begin
            streak_d = streak_q + STREAK_W'(1);
          end else begin
            streak_d = streak_q;
          end
        end else if (fetch_ok_s) begin
          state_d  = IF_BUSY;
          addr_d   = ifAddr;
          wdata_d  = '0;
          be_d     = 4'hF;
          we_d     = 1'b0;
          streak_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      IF_BUSY: begin
        // A killed fetch must still let the memory finish, so it drains instead of aborting.
        if (memReady) begin
          state_d = IDLE;
        end else if (ifKill) begin
          state_d = IF_DRAIN;
        end else begin
          state_d = IF_BUSY;
        end
      end
      D_BUSY: begin
        if (memReady) begin
          state_d = IDLE;
        end else begin
          state_d = D_BUSY;
        end
      end
      IF_DRAIN: begin
        if (memReady) begin
          state_d = IDLE;
        end else begin
          state_d = IF_DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign memReq   = (state_q != IDLE);
  assign memWe    = we_q;
  assign memAddr  = addr_q;
  assign memWdata = wdata_q;
  assign memBe    = be_q;

  assign ifDone  = (state_q == IF_BUSY) && memReady && !ifKill;
  assign dDone   = (state_q == D_BUSY) && memReady;
  assign ifRdata = memRdata;
  assign dRdata  = memRdata;
  assign ifStall = ifReq && !ifDone;
  assign dStall  = dReq && !dDone;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// reset/starvation sequences and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  logic        Clk, Rst;
  logic        ifReq, ifKill, ifDone, ifStall;
  logic [31:0] ifAddr, ifRdata;
  logic        dReq, dWe, dDone, dStall;
  logic [31:0] dAddr, dWdata, dRdata;
  logic [3:0]  dBe;
  logic        memReq, memWe, memReady;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [3:0]  memBe;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
    .Clk(Clk), .Rst(Rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifKill(ifKill), .ifDone(ifDone), .ifRdata(ifRdata), .ifStall(ifStall),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dBe(dBe),
    .dDone(dDone), .dRdata(dRdata), .dStall(dStall),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
    .memRdata(memRdata), .memReady(memReady)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        if_req;  logic [31:0] if_addr; logic if_kill;
    logic        d_req;   logic d_we; logic [31:0] d_addr; logic [31:0] d_wdata; logic [3:0] d_be;
    logic        rdy;     logic [31:0] rdata;
    logic        e_req;   logic e_we; logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wdata;
    logic        e_ifd;   logic e_dd; logic e_ifs; logic e_ds;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ir, input logic [31:0] ia, input logic ik,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                     input logic [3:0] db, input logic rdy, input logic [31:0] rd,
                     input logic er, input logic ew, input logic [31:0] ea, input logic [3:0] eb,
                     input logic [31:0] ewd, input logic eifd, input logic edd, input logic eifs, input logic eds);
    vec_t v;
    v = '{ir, ia, ik, dr, dw, da, dwd, db, rdy, rd, er, ew, ea, eb, ewd, eifd, edd, eifs, eds};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic ik,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                       input logic [3:0] db, input logic rdy, input logic [31:0] rd);
    ifReq = ir; ifAddr = ia; ifKill = ik;
    dReq = dr; dWe = dw; dAddr = da; dWdata = dwd; dBe = db;
    memReady = rdy; memRdata = rd;
  endtask

  // Transaction-level reference: who owns the memory, whether that fetch was abandoned,
  // how many data grants in a row have passed over a waiting fetch, and the granted fields.
  int          m_own;
  bit          m_dead;
  int          m_streak;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_we;

  task automatic model_cycle(output bit e_ifd, output bit e_dd);
    bit want_f;
    e_ifd = (m_own == 1) && memReady && !m_dead && !ifKill;
    e_dd  = (m_own == 2) && memReady;
    chk("rnd_memReq", memReq, (m_own != 0));
    chk("rnd_ifDone", ifDone, e_ifd);
    chk("rnd_dDone", dDone, e_dd);
    chk("rnd_ifStall", ifStall, ifReq && !e_ifd);
    chk("rnd_dStall", dStall, dReq && !e_dd);
    if (m_own != 0) begin
      chk("rnd_memAddr", memAddr, m_addr);
      chk("rnd_memWe", memWe, m_we);
      chk("rnd_memBe", memBe, m_be);
      if (m_we) chk("rnd_memWdata", memWdata, m_wdata);
    end
    if (e_ifd) chk("rnd_ifRdata", ifRdata, memRdata);
    if (e_dd) chk("rnd_dRdata", dRdata, memRdata);
    if (m_own != 0) begin
      if (memReady) begin
        m_own = 0; m_dead = 0;
      end else if (m_own == 1 && ifKill) begin
        m_dead = 1;
      end
    end else begin
      want_f = ifReq && !ifKill;
      if (dReq && !(want_f && m_streak == MAXS)) begin
        m_own = 2; m_addr = dAddr; m_we = dWe; m_be = dBe; m_wdata = dWdata;
        m_streak = ifReq ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else if (want_f) begin
        m_own = 1; m_addr = ifAddr; m_we = 1'b0; m_be = 4'hF; m_streak = 0;
      end
    end
  endtask

  initial begin
    string order;
    int    sim_s, ifd_cnt, cyc;
    bit    p_ifd, p_dd, p_kill, e_ifd, e_dd;
    logic  if_r, d_r;

    Rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_memReq", memReq, 0);
    chk("reset_memWe", memWe, 0);
    chk("reset_ifDone", ifDone, 0);
    chk("reset_dDone", dDone, 0);
    Rst = 1'b1;

    // if_req if_addr kill | d_req we d_addr d_wdata be | rdy rdata | memReq we addr be wdata | ifDone dDone ifStall dStall
    add(0, 32'h0, 0, 1, 0, 32'h100, 32'h0, 4'hF, 1, 32'hDEADBEEF, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 1);
    add(0, 32'h0, 0, 1, 0, 32'h100, 32'h0, 4'hF, 1, 32'hDEADBEEF, 1, 0, 32'h100, 4'hF, 32'h0, 0, 1, 0, 0);
    add(0, 32'h0, 0, 1, 1, 32'h204, 32'h11223344, 4'h3, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 1);
    add(0, 32'h0, 0, 1, 1, 32'h204, 32'h11223344, 4'h3, 0, 32'h0, 1, 1, 32'h204, 4'h3, 32'h11223344, 0, 0, 0, 1);
    add(0, 32'h0, 0, 1, 1, 32'h204, 32'h11223344, 4'h3, 1, 32'h0, 1, 1, 32'h204, 4'h3, 32'h11223344, 0, 1, 0, 0);
    add(1, 32'h00400000, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++)
      add(1, 32'h00400000, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1, 0, 32'h00400000, 4'hF, 32'h0, 0, 0, 1, 0);
    add(1, 32'h00400000, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hCAFEF00D, 1, 0, 32'h00400000, 4'hF, 32'h0, 1, 0, 0, 0);
    add(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0);
    add(1, 32'h80, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 0);
    add(1, 32'h80, 1, 1, 0, 32'h300, 32'h0, 4'hF, 0, 32'h0, 1, 0, 32'h80, 4'hF, 32'h0, 0, 0, 1, 1);
    add(0, 32'h80, 0, 1, 0, 32'h300, 32'h0, 4'hF, 0, 32'h0, 1, 0, 32'h80, 4'hF, 32'h0, 0, 0, 0, 1);
    add(0, 32'h80, 0, 1, 0, 32'h300, 32'h0, 4'hF, 1, 32'h12345678, 1, 0, 32'h80, 4'hF, 32'h0, 0, 0, 0, 1);
    add(0, 32'h80, 0, 1, 0, 32'h300, 32'h0, 4'hF, 1, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 1);
    add(0, 32'h80, 0, 1, 0, 32'h300, 32'h0, 4'hF, 1, 32'h55AA55AA, 1, 0, 32'h300, 4'hF, 32'h0, 0, 1, 0, 0);
    add(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0);
    add(1, 32'h84, 1, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 0);
    add(1, 32'h84, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 0);
    add(1, 32'h84, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0BADF00D, 1, 0, 32'h84, 4'hF, 32'h0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      @(posedge Clk); #1;
      drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].if_kill, vecs[i].d_req, vecs[i].d_we,
            vecs[i].d_addr, vecs[i].d_wdata, vecs[i].d_be, vecs[i].rdy, vecs[i].rdata);
      @(negedge Clk);
      chk($sformatf("vec%0d_memReq", i), memReq, vecs[i].e_req);
      chk($sformatf("vec%0d_ifDone", i), ifDone, vecs[i].e_ifd);
      chk($sformatf("vec%0d_dDone", i), dDone, vecs[i].e_dd);
      chk($sformatf("vec%0d_ifStall", i), ifStall, vecs[i].e_ifs);
      chk($sformatf("vec%0d_dStall", i), dStall, vecs[i].e_ds);
      if (vecs[i].e_req) begin
        chk($sformatf("vec%0d_memAddr", i), memAddr, vecs[i].e_addr);
        chk($sformatf("vec%0d_memWe", i), memWe, vecs[i].e_we);
        chk($sformatf("vec%0d_memBe", i), memBe, vecs[i].e_be);
        if (vecs[i].e_we) chk($sformatf("vec%0d_memWdata", i), memWdata, vecs[i].e_wdata);
      end
      if (vecs[i].e_ifd) chk($sformatf("vec%0d_ifRdata", i), ifRdata, vecs[i].rdata);
      if (vecs[i].e_dd) chk($sformatf("vec%0d_dRdata", i), dRdata, vecs[i].rdata);
    end

    // Reset dropped in the middle of a stalled load.
    @(posedge Clk); #1;
    drive(0, 0, 0, 1, 0, 32'h500, 0, 4'hF, 0, 32'h77);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("rst_mid_busy_memReq", memReq, 1);
    #2;
    Rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 32'h77);
    #1;
    chk("rst_mid_memReq", memReq, 0);
    chk("rst_mid_dDone", dDone, 0);
    chk("rst_mid_memWe", memWe, 0);
    @(negedge Clk);
    Rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("rst_after_memReq", memReq, 0);
      chk("rst_after_dDone", dDone, 0);
    end

    // Continuous contention: fetch must get through once every MAXS+1 transactions.
    @(posedge Clk); #1;
    drive(1, 32'h1000, 0, 1, 0, 32'h2000, 0, 4'hF, 1, 32'h0);
    order = ""; ifd_cnt = 0; cyc = 0;
    while (order.len() < 15 && cyc < 200) begin
      @(negedge Clk);
      cyc++;
      if (dDone) order = {order, "D"};
      if (ifDone) begin order = {order, "I"}; ifd_cnt++; end
      @(posedge Clk); #1;
      if (dDone) dAddr = dAddr + 32'h4;
      if (ifDone) ifAddr = ifAddr + 32'h4;
    end
    chk("starve_completed_15", (order.len() >= 15), 1);
    sim_s = 0;
    for (int k = 0; k < order.len() && k < 15; k++) begin
      byte exp_c;
      if (sim_s == MAXS) begin exp_c = "I"; sim_s = 0; end
      else begin exp_c = "D"; sim_s++; end
      chk($sformatf("starve_grant%0d", k), order[k], exp_c);
    end
    chk("starve_ifDone_count", ifd_cnt, 3);

    // Randomized traffic against the model.
    Rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    @(negedge Clk);
    Rst = 1'b1;
    m_own = 0; m_dead = 0; m_streak = 0;
    m_addr = '0; m_wdata = '0; m_be = '0; m_we = 1'b0;
    p_ifd = 0; p_dd = 0; p_kill = 0; if_r = 0; d_r = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge Clk); #1;
      if (!if_r || p_ifd || p_kill) begin
        if_r = ($urandom_range(0, 2) != 0);
        ifAddr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_r || p_dd) begin
        d_r = ($urandom_range(0, 2) == 0);
        dWe = $urandom_range(0, 1);
        dAddr = $urandom;
        dWdata = $urandom;
        dBe = 4'($urandom_range(0, 15));
      end
      ifReq = if_r; dReq = d_r;
      ifKill = ($urandom_range(0, 9) == 0);
      memReady = $urandom_range(0, 1);
      memRdata = $urandom;
      @(negedge Clk);
      model_cycle(e_ifd, e_dd);
      p_ifd = e_ifd; p_dd = e_dd; p_kill = ifKill;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
